// File: rtl/event_sched_pkg.sv
// Shared types and helpers for the event latch scheduler.
package event_sched_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // Widened sum, clamped at max_v; counters up to 32 bits.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max_v}) ? max_v : s[31:0];
    endfunction

endpackage

// File: rtl/event_latch_scheduler_if.sv
// Valid/ready offer channel from the scheduler to its single consumer.
interface event_latch_scheduler_if #(
    parameter int N = 4
);
    localparam int ID_W = $clog2(N);

    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic            evt_ready;

    modport master (output evt_valid, output evt_id, input evt_ready);
    modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/event_latch_scheduler_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] gnt_id,
    output logic            any_gnt
);
    int unsigned idx;

    always_comb begin
        gnt_id  = '0;
        any_gnt = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < unsigned'(N); i++) begin
            idx = (32'(ptr) + i) % unsigned'(N);
            if (!any_gnt && req[idx]) begin
                any_gnt = 1'b1;
                gnt_id  = idx[ID_W-1:0];
            end
        end
    end
endmodule

// File: rtl/event_latch_scheduler.sv
// Sticky event latches with overflow counting, handed out round-robin
// to one consumer over a registered valid/ready offer.
module event_latch_scheduler
    import event_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           event_in,
    input  logic [N-1:0]           mask,
    input  logic                   ovf_clr,
    event_latch_scheduler_if.master evt,
    output logic [N-1:0]           pending,
    output logic [CNT_W-1:0]       overflow_cnt,
    output logic                   busy
);
    localparam int ID_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t          state, state_n;
    logic [N-1:0]    prev;
    logic [N-1:0]    rise;
    logic [N-1:0]    clr_v;
    logic [N-1:0]    ovf_hit;
    logic [4:0]      ovf_inc;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_n;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gnt_id;
    logic            any_gnt;
    logic            load;
    logic            accept;

    rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
        .req     (pending & mask),
        .ptr     (ptr),
        .gnt_id  (gnt_id),
        .any_gnt (any_gnt)
    );

    always_comb begin
        state_n = state;
        load    = 1'b0;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (any_gnt) begin
                    state_n = OFFER;
                    load    = 1'b1;
                end
            end
            OFFER: begin
                if (evt.evt_ready) begin
                    accept  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A rising edge on the channel being retired re-arms it and is not an overflow.
    always_comb begin
        rise  = event_in & ~prev;
        clr_v = '0;
        if (accept) clr_v[evt.evt_id] = 1'b1;
        ovf_hit = rise & pending & ~clr_v;
        ovf_inc = '0;
        for (int unsigned i = 0; i < unsigned'(N); i++)
            ovf_inc = ovf_inc + {4'b0000, ovf_hit[i]};
        cnt_base = ovf_clr ? '0 : overflow_cnt;
        cnt_n    = CNT_W'(sat_add(32'(cnt_base), 32'(ovf_inc), 32'(CNT_MAX)));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            prev          <= '0;
            pending       <= '0;
            ptr           <= '0;
            overflow_cnt  <= '0;
            evt.evt_valid <= 1'b0;
            evt.evt_id    <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            prev          <= event_in;
            pending       <= (pending & ~clr_v) | rise;
            overflow_cnt  <= cnt_n;
            evt.evt_valid <= (state_n == OFFER);
            busy          <= (state_n == OFFER);
            if (load) evt.evt_id <= gnt_id;
            if (accept)
                ptr <= (evt.evt_id == ID_W'(N - 1)) ? '0 : evt.evt_id + 1'b1;
        end
    end
endmodule

// File: tb/tb_event_latch_scheduler.sv
// Scoreboard bench: expected grant ids queued at stimulus time, checked on handshake.
module tb_event_latch_scheduler;
    localparam int N     = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     event_in;
    logic [N-1:0]     mask;
    logic             ovf_clr;
    logic [N-1:0]     pending;
    logic [CNT_W-1:0] overflow_cnt;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int unsigned exp_q[$];

    event_latch_scheduler_if #(.N(N)) evt ();

    event_latch_scheduler #(.N(N), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .event_in     (event_in),
        .mask         (mask),
        .ovf_clr      (ovf_clr),
        .evt          (evt),
        .pending      (pending),
        .overflow_cnt (overflow_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Handshake monitor: an accepted offer must match the oldest expected id.
    always @(negedge clk) begin
        if (rst && evt.evt_valid && evt.evt_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL offer_unexpected: got id=%0d, expected none", evt.evt_id);
            end else begin
                int unsigned e;
                e = exp_q.pop_front();
                if (32'(evt.evt_id) !== e) begin
                    bad++;
                    $display("FAIL offer_id: got %0d, expected %0d", evt.evt_id, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [N-1:0] v);
        event_in = v;
        tick();
        event_in = '0;
        tick();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        event_in = '0;
        ovf_clr = 1'b0;
        evt.evt_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        mask = '1;
        apply_reset();
        total++;
        if (evt.evt_valid !== 1'b0 || busy !== 1'b0 || pending !== '0 ||
            overflow_cnt !== '0 || evt.evt_id !== '0) begin
            bad++;
            $display("FAIL reset_state: valid=%b busy=%b pend=%b cnt=%0d id=%0d, expected all 0",
                     evt.evt_valid, busy, pending, overflow_cnt, evt.evt_id);
        end
    endtask

    task automatic test_single();
        mask = 4'hF;
        evt.evt_ready = 1'b1;
        event_in = 4'b0100;
        exp_q.push_back(2);
        tick();
        event_in = '0;
        total++;
        if (pending !== 4'b0100 || evt.evt_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_pending: pend=%b valid=%b, expected 0100 0", pending, evt.evt_valid);
        end
        tick();
        total++;
        if (evt.evt_valid !== 1'b1 || evt.evt_id !== 2'd2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_offer: valid=%b id=%0d busy=%b, expected 1 2 1",
                     evt.evt_valid, evt.evt_id, busy);
        end
        tick();
        total++;
        if (pending !== '0 || evt.evt_valid !== 1'b0 || overflow_cnt !== '0) begin
            bad++;
            $display("FAIL single_done: pend=%b valid=%b cnt=%0d, expected 0 0 0",
                     pending, evt.evt_valid, overflow_cnt);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        mask = 4'hF;
        evt.evt_ready = 1'b1;
        event_in = 4'hF;
        for (int unsigned i = 0; i < 4; i++) exp_q.push_back(i);
        tick();
        event_in = '0;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if (evt.evt_valid !== ((k % 2) == 0)) begin
                bad++;
                $display("FAIL rr_gap: cycle %0d valid=%b, expected %b", k, evt.evt_valid, (k % 2) == 0);
            end
        end
        event_in = 4'b1001;
        exp_q.push_back(0);
        exp_q.push_back(3);
        tick();
        event_in = '0;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
        total++;
        if (exp_q.size() != 0 || pending !== '0) begin
            bad++;
            $display("FAIL rr_rearm: left=%0d pend=%b, expected 0 0000", exp_q.size(), pending);
        end
    endtask

    task automatic test_mask();
        mask = 4'b1101;
        evt.evt_ready = 1'b1;
        pulse(4'b0010);
        tick();
        tick();
        total++;
        if (pending !== 4'b0010 || evt.evt_valid !== 1'b0) begin
            bad++;
            $display("FAIL mask_hold: pend=%b valid=%b, expected 0010 0", pending, evt.evt_valid);
        end
        mask = 4'hF;
        exp_q.push_back(1);
        for (int k = 0; k < 4 && exp_q.size() != 0; k++) tick();
        total++;
        if (exp_q.size() != 0 || pending !== '0) begin
            bad++;
            $display("FAIL mask_release: left=%0d pend=%b, expected 0 0000", exp_q.size(), pending);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        mask = '0;
        pulse(4'b0001);
        pulse(4'b0001);
        pulse(4'b0001);
        total++;
        if (overflow_cnt !== 2'd2) begin
            bad++;
            $display("FAIL ovf_count: got %0d, expected 2", overflow_cnt);
        end
        pulse(4'b0001);
        pulse(4'b0001);
        total++;
        if (overflow_cnt !== 2'd3) begin
            bad++;
            $display("FAIL ovf_saturate: got %0d, expected 3", overflow_cnt);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        total++;
        if (overflow_cnt !== 2'd0) begin
            bad++;
            $display("FAIL ovf_clear: got %0d, expected 0", overflow_cnt);
        end
        pulse(4'b0010);
        pulse(4'b0011);
        total++;
        if (overflow_cnt !== 2'd2 || pending !== 4'b0011) begin
            bad++;
            $display("FAIL ovf_multi: cnt=%0d pend=%b, expected 2 0011", overflow_cnt, pending);
        end
        event_in = 4'b0001;
        ovf_clr = 1'b1;
        tick();
        event_in = '0;
        ovf_clr = 1'b0;
        total++;
        if (overflow_cnt !== 2'd1) begin
            bad++;
            $display("FAIL ovf_clr_inc: got %0d, expected 1", overflow_cnt);
        end
        tick();
    endtask

    task automatic test_set_wins();
        apply_reset();
        mask = 4'hF;
        exp_q.push_back(2);
        pulse(4'b0100);
        total++;
        if (evt.evt_valid !== 1'b1 || evt.evt_id !== 2'd2) begin
            bad++;
            $display("FAIL sw_offer: valid=%b id=%0d, expected 1 2", evt.evt_valid, evt.evt_id);
        end
        evt.evt_ready = 1'b1;
        event_in = 4'b0100;
        exp_q.push_back(2);
        tick();
        event_in = '0;
        total++;
        if (pending !== 4'b0100 || overflow_cnt !== '0 || evt.evt_valid !== 1'b0) begin
            bad++;
            $display("FAIL sw_collide: pend=%b cnt=%0d valid=%b, expected 0100 0 0",
                     pending, overflow_cnt, evt.evt_valid);
        end
        for (int k = 0; k < 6 && exp_q.size() != 0; k++) tick();
        total++;
        if (exp_q.size() != 0 || pending !== '0) begin
            bad++;
            $display("FAIL sw_reoffer: left=%0d pend=%b, expected 0 0000", exp_q.size(), pending);
        end
    endtask

    task automatic test_reset_mid_offer();
        mask = 4'hF;
        evt.evt_ready = 1'b0;
        pulse(4'b0010);
        total++;
        if (evt.evt_valid !== 1'b1) begin
            bad++;
            $display("FAIL rmo_offer: valid=%b, expected 1", evt.evt_valid);
        end
        rst = 1'b0;
        tick();
        total++;
        if (evt.evt_valid !== 1'b0 || pending !== '0 || busy !== 1'b0 || overflow_cnt !== '0) begin
            bad++;
            $display("FAIL rmo_cleared: valid=%b pend=%b busy=%b cnt=%0d, expected 0 0 0 0",
                     evt.evt_valid, pending, busy, overflow_cnt);
        end
        rst = 1'b1;
        evt.evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (evt.evt_valid !== 1'b0) begin
                bad++;
                $display("FAIL rmo_quiet: cycle %0d valid=%b, expected 0", k, evt.evt_valid);
            end
        end
        exp_q.push_back(3);
        pulse(4'b1000);
        for (int k = 0; k < 4 && exp_q.size() != 0; k++) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rmo_new_event: left=%0d, expected 0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b0;
        event_in = '0;
        mask = '1;
        ovf_clr = 1'b0;
        evt.evt_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_mask();
        test_overflow();
        test_set_wins();
        test_reset_mid_offer();
        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left=%0d, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time %0t, expected finish earlier", $time);
        $fatal(1);
    end
endmodule
